// File: rtl/bip2_imem_loader_pkg.sv
// Shared definitions for the BIP2 instruction-memory loader.
// - LD_W      : width of the loader byte port
// - ld_state_e: loader FSM states
// - rom_depth : number of words addressable by an address of the given width
package bip2_imem_loader_pkg;

  localparam int LD_W = 8;

  typedef enum logic [2:0] {
    S_CNT_HI,
    S_CNT_LO,
    S_DAT_HI,
    S_DAT_LO,
    S_CHK,
    S_RUN,
    S_ERR
  } ld_state_e;

  function automatic int rom_depth(input int aw);
    return 1 << aw;
  endfunction

endpackage

// File: rtl/bip2_imem_ram.sv
// Program memory for the BIP2 loader: one synchronous write port, one
// asynchronous (combinational) read port. Contents are not reset.
// Ports:
//   clk_i     system clock
//   we_i      write enable
//   waddr_i   write address
//   wdata_i   write data
//   raddr_i   read address
//   rdata_o   read data, combinational from raddr_i
module bip2_imem_ram #(
  parameter int DW = 16,
  parameter int AW = 11
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/bip2_imem_loader.sv
// BIP2 instruction-memory loader. Receives a framed program image on a
// valid/ready byte port, stores it, and then serves the CPU like a ROM.
// Frame: CNT_HI CNT_LO {W_HI W_LO} x N CHK, CHK = XOR of all prior bytes.
// Ports:
//   CLOCK_i      system clock
//   RESET_i      asynchronous active-high reset
//   LD_VALID_i   loader byte valid
//   LD_DATA_i    loader byte
//   LD_READY_o   loader byte ready (accept on VALID & READY)
//   ADDR_im_i    CPU instruction address
//   DATA_im_o    CPU instruction word (combinational, 0 outside loaded image)
//   CPU_RESET_o  processor reset, held until a valid image is stored
//   LOAD_DONE_o  image stored and checksum accepted
//   LOAD_ERR_o   framing or checksum error, sticky until RESET_i
module bip2_imem_loader
  import bip2_imem_loader_pkg::*;
#(
  parameter int MSB_DATA = 16,
  parameter int MSB_ROM  = 11,
  parameter int LSB      = 0
) (
  input  logic                        CLOCK_i,
  input  logic                        RESET_i,
  input  logic                        LD_VALID_i,
  input  logic [LSB+LD_W-1:LSB]       LD_DATA_i,
  output logic                        LD_READY_o,
  input  logic [LSB+MSB_ROM-1:LSB]    ADDR_im_i,
  output logic [LSB+MSB_DATA-1:LSB]   DATA_im_o,
  output logic                        CPU_RESET_o,
  output logic                        LOAD_DONE_o,
  output logic                        LOAD_ERR_o
);

  localparam int DEPTH = rom_depth(MSB_ROM);
  localparam logic [2*LD_W-1:0] DEPTH_W = (2*LD_W)'(DEPTH);
  localparam logic [MSB_ROM:0]  ONE_A   = {{MSB_ROM{1'b0}}, 1'b1};

  ld_state_e         state_q, state_d;
  // Word address and count carry one extra bit so a full 2**MSB_ROM image
  // is representable and the write address never wraps.
  logic [MSB_ROM:0]  waddr_q, waddr_d, waddr_inc;
  logic [MSB_ROM:0]  n_q, n_d;
  logic [LD_W-1:0]   hi_q, hi_d;
  logic [LD_W-1:0]   acc_q, acc_d;
  logic              cpu_rst_q;
  logic              accept, we;
  logic [2*LD_W-1:0] cnt;
  logic [MSB_DATA-1:0] wdata, rdata;

  assign LD_READY_o = (state_q != S_RUN) && (state_q != S_ERR);
  assign accept     = LD_VALID_i && LD_READY_o;
  assign cnt        = {hi_q, LD_DATA_i};
  assign waddr_inc  = waddr_q + ONE_A;
  assign wdata      = MSB_DATA'({hi_q, LD_DATA_i});

  always_comb begin
    state_d = state_q;
    waddr_d = waddr_q;
    n_d     = n_q;
    hi_d    = hi_q;
    acc_d   = acc_q;
    we      = 1'b0;
    if (accept) begin
      acc_d = acc_q ^ LD_DATA_i;
      case (state_q)
        S_CNT_HI: begin
          hi_d    = LD_DATA_i;
          state_d = S_CNT_LO;
        end
        S_CNT_LO: begin
          if (cnt == '0 || cnt > DEPTH_W) begin
            state_d = S_ERR;
          end else begin
            n_d     = cnt[MSB_ROM:0];
            waddr_d = '0;
            state_d = S_DAT_HI;
          end
        end
        S_DAT_HI: begin
          hi_d    = LD_DATA_i;
          state_d = S_DAT_LO;
        end
        S_DAT_LO: begin
          we      = 1'b1;
          waddr_d = waddr_inc;
          state_d = (waddr_inc == n_q) ? S_CHK : S_DAT_HI;
        end
        S_CHK:   state_d = (LD_DATA_i == acc_q) ? S_RUN : S_ERR;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge CLOCK_i or posedge RESET_i) begin
    if (RESET_i) begin
      state_q   <= S_CNT_HI;
      waddr_q   <= '0;
      n_q       <= '0;
      hi_q      <= '0;
      acc_q     <= '0;
      cpu_rst_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      waddr_q   <= waddr_d;
      n_q       <= n_d;
      hi_q      <= hi_d;
      acc_q     <= acc_d;
      // Registered from next state so the CPU leaves reset on the very edge
      // that enters S_RUN.
      cpu_rst_q <= (state_d != S_RUN);
    end
  end

  bip2_imem_ram #(
    .DW (MSB_DATA),
    .AW (MSB_ROM)
  ) u_ram (
    .clk_i   (CLOCK_i),
    .we_i    (we),
    .waddr_i (waddr_q[MSB_ROM-1:0]),
    .wdata_i (wdata),
    .raddr_i (ADDR_im_i),
    .rdata_o (rdata)
  );

  // Unloaded words and pre-RUN contents read as zero, hiding stale RAM.
  assign DATA_im_o   = (state_q == S_RUN && {1'b0, ADDR_im_i} < n_q) ? rdata : '0;
  assign CPU_RESET_o = cpu_rst_q;
  assign LOAD_DONE_o = (state_q == S_RUN);
  assign LOAD_ERR_o  = (state_q == S_ERR);

endmodule
